// File: rtl/pipe_mul32.sv
// -----------------------------------------------------------------------------
// pipe_mul32 -- 32x32 -> 64-bit four-stage pipelined multiplier
//
// Stages (all advance together on adv, all hold otherwise):
//   S1 operand latch, S2 four 8-bit-slice partial products,
//   S3 two pair sums (CLA64), S4 final sum (CLA64) -> product.
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   flush      synchronous; clears every stage valid bit at the next edge
//   in_valid   operand beat present
//   in_ready   pipeline can accept a beat this cycle (= adv)
//   a, b       32-bit multiplicand / multiplier
//   is_signed  only with PIPE_MUL32_SIGNED_EN: treat a/b as two's complement
//   out_valid  product beat present
//   out_ready  consumer accepts product this cycle
//   product    64-bit result, valid when out_valid
//
// Optional feature macro: PIPE_MUL32_SIGNED_EN (signed multiply support).
// Also contains cla64, the 64-bit carry-lookahead adder used by S3/S4.
// -----------------------------------------------------------------------------

// cla64 -- 64-bit parallel-prefix (Kogge-Stone) carry-lookahead adder.
//   a, b  addends; cin carry in; sum = a + b + cin; cout carry out.
module cla64 (
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic        cin,
  output logic [63:0] sum,
  output logic        cout
);

  logic [63:0] g, p;
  logic [63:0] gp, pg;
  logic [63:0] ng, np;

  always_comb begin
    g  = a & b;
    p  = a ^ b;
    gp = g;
    pg = p;
    ng = '0;
    np = '0;
    // After the six prefix levels gp[i]/pg[i] are group generate/propagate
    // over bits [i:0].
    for (int unsigned lvl = 0; lvl < 6; lvl++) begin
      ng = gp;
      np = pg;
      for (int unsigned i = 0; i < 64; i++) begin
        if (i >= (32'd1 << lvl)) begin
          ng[i] = gp[i] | (pg[i] & gp[i - (32'd1 << lvl)]);
          np[i] = pg[i] & pg[i - (32'd1 << lvl)];
        end
      end
      gp = ng;
      pg = np;
    end
    sum  = p ^ {gp[62:0] | (pg[62:0] & {63{cin}}), cin};
    cout = gp[63] | (pg[63] & cin);
  end

endmodule

module pipe_mul32 #(
  parameter int STAGES = 4,
  parameter int WIDTH  = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
`ifdef PIPE_MUL32_SIGNED_EN
  input  logic        is_signed,
`endif
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] product
);

  // Stage valid bits and data registers
  logic        v1, v2, v3;
  logic [31:0] a1, b1;
  logic [63:0] pp0, pp1, pp2, pp3;
  logic [63:0] s01, s23;

  logic        adv;
  logic [31:0] a_mag, b_mag;
  logic [63:0] pp_next [4];
  logic [63:0] s01_next, s23_next, sum_next, prod_next;

  // Carry-outs cannot be set for a 32x32 product; kept only as sinks.
  logic unused_cout01, unused_cout23, unused_cout_fin;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

`ifdef PIPE_MUL32_SIGNED_EN
  logic        neg1, neg2, neg3;
  logic        neg_in;
  logic [63:0] neg_sum;
  logic        unused_cout_neg;

  // |0x80000000| wraps back to 0x80000000, which is the correct unsigned magnitude.
  assign a_mag  = (is_signed && a[31]) ? (~a + 32'd1) : a;
  assign b_mag  = (is_signed && b[31]) ? (~b + 32'd1) : b;
  assign neg_in = is_signed && (a[31] ^ b[31]);

  cla64 u_cla_neg (
    .a    (~sum_next),
    .b    ('0),
    .cin  (1'b1),
    .sum  (neg_sum),
    .cout (unused_cout_neg)
  );

  assign prod_next = neg3 ? neg_sum : sum_next;
`else
  assign a_mag     = a;
  assign b_mag     = b;
  assign prod_next = sum_next;
`endif

  // S2 combinational: 32x8 slices, zero-extended and aligned to their byte.
  always_comb begin
    for (int unsigned k = 0; k < 4; k++) begin
      pp_next[k] = {24'b0, 40'(a1) * 40'(b1[8*k +: 8])} << (8 * k);
    end
  end

  cla64 u_cla_s01 (
    .a    (pp0),
    .b    (pp1),
    .cin  (1'b0),
    .sum  (s01_next),
    .cout (unused_cout01)
  );

  cla64 u_cla_s23 (
    .a    (pp2),
    .b    (pp3),
    .cin  (1'b0),
    .sum  (s23_next),
    .cout (unused_cout23)
  );

  cla64 u_cla_fin (
    .a    (s01),
    .b    (s23),
    .cin  (1'b0),
    .sum  (sum_next),
    .cout (unused_cout_fin)
  );

  // Valid bits: flush wins over adv; bubbles shift like beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      v3        <= 1'b0;
      out_valid <= 1'b0;
    end else if (flush) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      v3        <= 1'b0;
      out_valid <= 1'b0;
    end else if (adv) begin
      v1        <= in_valid;
      v2        <= v1;
      v3        <= v2;
      out_valid <= v3;
    end
  end

  // Data path: shifts on adv regardless of flush (stale data is harmless).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a1      <= '0;
      b1      <= '0;
      pp0     <= '0;
      pp1     <= '0;
      pp2     <= '0;
      pp3     <= '0;
      s01     <= '0;
      s23     <= '0;
      product <= '0;
    end else if (adv) begin
      a1      <= a_mag;
      b1      <= b_mag;
      pp0     <= pp_next[0];
      pp1     <= pp_next[1];
      pp2     <= pp_next[2];
      pp3     <= pp_next[3];
      s01     <= s01_next;
      s23     <= s23_next;
      product <= prod_next;
    end
  end

`ifdef PIPE_MUL32_SIGNED_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg1 <= 1'b0;
      neg2 <= 1'b0;
      neg3 <= 1'b0;
    end else if (adv) begin
      neg1 <= neg_in;
      neg2 <= neg1;
      neg3 <= neg2;
    end
  end
`endif

endmodule
